// File: rtl/sd_spi_responder_if.sv
// Bus bundle for sd_spi_responder: SPI pins plus the command, read and write
// side ports. The host/environment side uses "master", the card model uses "slave".
interface sd_spi_responder_if;
  logic        spi_clk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        initialized;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [8:0]  rd_index;
  logic [7:0]  rd_data;
  logic        wr_valid;
  logic [8:0]  wr_index;
  logic [7:0]  wr_data;

  modport master (output spi_clk, cs, mosi, rd_data,
                  input  miso, cmd_valid, cmd_index, cmd_arg, initialized,
                         rd_req, rd_addr, rd_index, wr_valid, wr_index, wr_data);
  modport slave  (input  spi_clk, cs, mosi, rd_data,
                  output miso, cmd_valid, cmd_index, cmd_arg, initialized,
                         rd_req, rd_addr, rd_index, wr_valid, wr_index, wr_data);
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card model. Oversamples the SPI pins in the clk domain, decodes
// 48-bit command frames, answers R1/R3/R7, serves CMD17 reads from a byte
// request port and CMD24 writes onto a byte strobe port.
// Optional: define SD_RESP_CRC_CHECK_EN to check CMD0/CMD8 CRC7 and write CRC16.
module sd_spi_responder #(
  parameter int NCR_BYTES  = 1,
  parameter int NAC_BYTES  = 2,
  parameter int BUSY_BYTES = 4
) (
  input logic clk,
  input logic btn,
  sd_spi_responder_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_NCR, S_RESP, S_RD_NAC, S_RD_TOKEN, S_RD_DATA, S_RD_CRC,
    S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_BUSY
  } state_t;

  state_t      state;
  logic [2:0]  sclk_q;
  logic [1:0]  cs_q, mosi_q;
  logic [2:0]  bit_cnt, cmd_cnt, resp_left;
  logic [6:0]  rx_sr;
  logic [7:0]  tx_sr, tx_byte, rd_buf, cnt;
  logic [37:0] frame;
  logic [39:0] resp_sr;
  logic [8:0]  idx;
  logic        idle, pend, acmd_once, go_rd, go_wr;

  // edge detect sits behind the two synchronizer flops
  wire       rise      = sclk_q[1] & ~sclk_q[2];
  wire       fall      = ~sclk_q[1] & sclk_q[2];
  wire       sel       = ~cs_q[1];
  wire [7:0] rx_byte   = {rx_sr, mosi_q[1]};
  wire       byte_done = sel & rise & (bit_cnt == 3'd7);
  wire [5:0] cmd_idx   = frame[37:32];
  wire [31:0] arg      = frame[31:0];

  logic [7:0]  r1;
  logic [39:0] d_resp;
  logic [2:0]  d_len;
  logic        d_rd, d_wr, d_bad;

`ifdef SD_RESP_CRC_CHECK_EN
  logic [15:0] crc16;
  logic [7:0]  crc_hi;
  logic        wr_bad;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c = '0;
    for (int i = 39; i >= 0; i--) begin
      logic fb = c[6] ^ d[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c = c_in;
    for (int i = 7; i >= 0; i--) begin
      logic fb = c[15] ^ b[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
`endif

  // two-flop synchronizers for the SPI pins
  always_ff @(posedge clk or posedge btn) begin
    if (btn) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '1;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_clk};
      cs_q   <= {cs_q[0], bus.cs};
      mosi_q <= {mosi_q[0], bus.mosi};
    end
  end

  // command decode: response bytes and follow-on payload for a completed frame
  always_comb begin
    r1     = {7'd0, idle};
    d_resp = '0;
    d_len  = 3'd1;
    d_rd   = 1'b0;
    d_wr   = 1'b0;
    d_bad  = 1'b0;
    case (cmd_idx)
      6'd0:  d_resp[39:32] = 8'h01;
      6'd8:  begin d_resp = {r1, 16'h0000, 4'h0, arg[11:8], arg[7:0]}; d_len = 3'd5; end
      6'd55: d_resp[39:32] = r1;
      6'd41: d_resp[39:32] = pend ? (acmd_once ? 8'h00 : r1) : (r1 | 8'h04);
      6'd58: begin d_resp = {r1, 32'hC0FF_8000}; d_len = 3'd5; end
      6'd17: begin
        d_resp[39:32] = bus.initialized ? r1 : (r1 | 8'h04);
        d_rd          = bus.initialized;
      end
      6'd24: begin
        d_resp[39:32] = bus.initialized ? r1 : (r1 | 8'h04);
        d_wr          = bus.initialized;
      end
      default: d_resp[39:32] = r1 | 8'h04;
    endcase
`ifdef SD_RESP_CRC_CHECK_EN
    if ((cmd_idx == 6'd0 || cmd_idx == 6'd8) && crc7({2'b01, frame}) != rx_byte[7:1]) begin
      d_bad  = 1'b1;
      d_resp = {r1 | 8'h08, 32'd0};
      d_len  = 3'd1;
      d_rd   = 1'b0;
      d_wr   = 1'b0;
    end
`endif
  end

  // bit shifting, byte framing and the protocol FSM; tx_byte is chosen at each
  // byte boundary and loaded onto miso at the following spi_clk fall
  always_ff @(posedge clk or posedge btn) begin
    if (btn) begin
      state <= S_IDLE; bit_cnt <= '0; cmd_cnt <= '0; resp_left <= '0;
      rx_sr <= '0; tx_sr <= 8'hFF; tx_byte <= 8'hFF; rd_buf <= '0; cnt <= '0;
      frame <= '0; resp_sr <= '0; idx <= '0;
      idle <= 1'b1; pend <= 1'b0; acmd_once <= 1'b0; go_rd <= 1'b0; go_wr <= 1'b0;
      bus.miso <= 1'b1; bus.cmd_valid <= 1'b0; bus.cmd_index <= '0; bus.cmd_arg <= '0;
      bus.initialized <= 1'b0; bus.rd_req <= 1'b0; bus.rd_addr <= '0; bus.rd_index <= '0;
      bus.wr_valid <= 1'b0; bus.wr_index <= '0; bus.wr_data <= '0;
`ifdef SD_RESP_CRC_CHECK_EN
      crc16 <= '0; crc_hi <= '0; wr_bad <= 1'b0;
`endif
    end else begin
      bus.cmd_valid <= 1'b0;
      bus.rd_req    <= 1'b0;
      bus.wr_valid  <= 1'b0;
      if (bus.rd_req) rd_buf <= bus.rd_data;
      if (!sel) begin
        state <= S_IDLE; bit_cnt <= '0; tx_sr <= 8'hFF; tx_byte <= 8'hFF; bus.miso <= 1'b1;
      end else begin
        if (fall) begin
          if (bit_cnt == 3'd0) begin
            bus.miso <= tx_byte[7]; tx_sr <= {tx_byte[6:0], 1'b1};
          end else begin
            bus.miso <= tx_sr[7]; tx_sr <= {tx_sr[6:0], 1'b1};
          end
        end
        if (rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          tx_byte <= 8'hFF;
          case (state)
            S_IDLE: if (rx_byte[7:6] == 2'b01) begin
              frame <= {32'd0, rx_byte[5:0]}; cmd_cnt <= 3'd1; state <= S_CMD;
            end
            S_CMD: if (cmd_cnt == 3'd5) begin
              resp_sr <= d_resp; resp_left <= d_len - 3'd1;
              go_rd <= d_rd; go_wr <= d_wr;
              cnt <= 8'(NCR_BYTES - 1); state <= S_NCR;
              if (!d_bad) begin
                bus.cmd_valid <= 1'b1; bus.cmd_index <= cmd_idx; bus.cmd_arg <= arg;
                pend <= (cmd_idx == 6'd55);
                if (cmd_idx == 6'd0) idle <= 1'b1;
                if (cmd_idx == 6'd41 && pend) begin
                  if (acmd_once) begin idle <= 1'b0; bus.initialized <= 1'b1; end
                  else acmd_once <= 1'b1;
                end
                if (d_rd) bus.rd_addr <= arg;
              end
            end else begin
              frame <= {frame[29:0], rx_byte}; cmd_cnt <= cmd_cnt + 3'd1;
            end
            S_NCR: if (cnt == 8'd0) begin
              tx_byte <= resp_sr[39:32]; resp_sr <= resp_sr << 8; state <= S_RESP;
            end else cnt <= cnt - 8'd1;
            S_RESP: if (resp_left == 3'd0) begin
              if (go_rd) begin state <= S_RD_NAC; cnt <= 8'(NAC_BYTES - 1); end
              else if (go_wr) state <= S_WR_TOKEN;
              else state <= S_IDLE;
            end else begin
              tx_byte <= resp_sr[39:32]; resp_sr <= resp_sr << 8; resp_left <= resp_left - 3'd1;
            end
            // each data byte is requested one byte ahead of when it is shifted out
            S_RD_NAC: if (cnt == 8'd0) begin
              tx_byte <= 8'hFE; state <= S_RD_TOKEN; bus.rd_req <= 1'b1; bus.rd_index <= 9'd0;
            end else cnt <= cnt - 8'd1;
            S_RD_TOKEN: begin
              tx_byte <= rd_buf; idx <= '0; state <= S_RD_DATA;
              bus.rd_req <= 1'b1; bus.rd_index <= 9'd1;
            end
            S_RD_DATA: if (idx == 9'd511) begin
              state <= S_RD_CRC; cnt <= 8'd1;
            end else begin
              tx_byte <= rd_buf; idx <= idx + 9'd1;
              if (idx != 9'd510) begin bus.rd_req <= 1'b1; bus.rd_index <= idx + 9'd2; end
            end
            S_RD_CRC: if (cnt == 8'd0) state <= S_IDLE; else cnt <= cnt - 8'd1;
            S_WR_TOKEN: if (rx_byte == 8'hFE) begin
              state <= S_WR_DATA; idx <= '0;
`ifdef SD_RESP_CRC_CHECK_EN
              crc16 <= '0;
`endif
            end
            S_WR_DATA: begin
              bus.wr_valid <= 1'b1; bus.wr_data <= rx_byte; bus.wr_index <= idx;
              idx <= idx + 9'd1;
`ifdef SD_RESP_CRC_CHECK_EN
              crc16 <= crc16_byte(crc16, rx_byte);
`endif
              if (idx == 9'd511) begin state <= S_WR_CRC; cnt <= 8'd1; end
            end
            S_WR_CRC: if (cnt == 8'd0) begin
              state <= S_WR_RESP;
`ifdef SD_RESP_CRC_CHECK_EN
              wr_bad  <= ({crc_hi, rx_byte} != crc16);
              tx_byte <= ({crc_hi, rx_byte} != crc16) ? 8'h0B : 8'h05;
`else
              tx_byte <= 8'h05;
`endif
            end else begin
              cnt <= cnt - 8'd1;
`ifdef SD_RESP_CRC_CHECK_EN
              crc_hi <= rx_byte;
`endif
            end
            S_WR_RESP:
`ifdef SD_RESP_CRC_CHECK_EN
              if (wr_bad) state <= S_IDLE; else
`endif
              begin tx_byte <= 8'h00; state <= S_BUSY; cnt <= 8'(BUSY_BYTES - 1); end
            S_BUSY: if (cnt == 8'd0) state <= S_IDLE;
              else begin tx_byte <= 8'h00; cnt <= cnt - 8'd1; end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: init sequence, CMD17 read, CMD24 write,
// deselect mid-read and reset mid-read, with hand-computed expected bytes.
module tb_sd_spi_responder;
  logic clk = 1'b0;
  logic btn = 1'b1;
  always #5 clk = ~clk;

  sd_spi_responder_if bus();
  sd_spi_responder dut (.clk(clk), .btn(btn), .bus(bus));

  // host-side memory model: byte k of the block reads back as k[7:0]
  assign bus.rd_data = bus.rd_index[7:0];

  int total = 0, bad = 0;
  int cv_cnt = 0, rq_cnt = 0, rq_bad = 0, wv_cnt = 0, wv_bad = 0;
  logic [5:0] cv_idx = '0;

  // strobe monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.cmd_valid) begin cv_cnt <= cv_cnt + 1; cv_idx <= bus.cmd_index; end
    if (bus.rd_req) begin
      rq_cnt <= rq_cnt + 1;
      if (bus.rd_index != 9'(rq_cnt)) rq_bad <= rq_bad + 1;
    end
    if (bus.wr_valid) begin
      wv_cnt <= wv_cnt + 1;
      if (bus.wr_data != 8'hA5 || bus.wr_index != 9'(wv_cnt)) wv_bad <= wv_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one mode-0 byte, 3 clk per half period; miso sampled just before the rise
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = tx[i];
      repeat (3) @(negedge clk);
      rx[i] = bus.miso;
      bus.spi_clk = 1'b1;
      repeat (3) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic cmd(input logic [7:0] c, input logic [31:0] a, input logic [7:0] crc);
    logic [7:0] b;
    xfer(c, b); xfer(a[31:24], b); xfer(a[23:16], b);
    xfer(a[15:8], b); xfer(a[7:0], b); xfer(crc, b);
  endtask

  task automatic rd_n(input int n, output logic [63:0] got);
    logic [7:0] b;
    got = '0;
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, b);
      got = {got[55:0], b};
    end
  endtask

  task automatic cs_set(input logic v);
    bus.cs = v;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [7:0]  b;
    int          dbad, rq0, wv0, cv0;
    bus.spi_clk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_miso", 64'(bus.miso), 64'd1);
    chk("rst_cmd", 64'({bus.cmd_valid, bus.cmd_index, bus.cmd_arg, bus.initialized}), 64'd0);
    chk("rst_rd", 64'({bus.rd_req, bus.rd_addr, bus.rd_index}), 64'd0);
    chk("rst_wr", 64'({bus.wr_valid, bus.wr_index, bus.wr_data}), 64'd0);
    btn = 1'b0;
    repeat (4) @(negedge clk);

    // init sequence
    cs_set(1'b0);
    cv0 = cv_cnt;
    cmd(8'h40, 32'h0, 8'h95); rd_n(2, r);
    chk("cmd0_r1", r, 64'hFF01);
    chk("cmd0_valid", 64'(cv_cnt - cv0), 64'd1);
    chk("cmd0_idx", 64'(cv_idx), 64'd0);
    cmd(8'h48, 32'h0000_01AA, 8'h87); rd_n(6, r);
    chk("cmd8_r7", r, 64'hFF01_0000_01AA);
    chk("cmd8_arg", 64'(bus.cmd_arg), 64'h1AA);
    cmd(8'h77, 32'h0, 8'h65); rd_n(2, r); chk("cmd55_a", r, 64'hFF01);
    cmd(8'h69, 32'h4000_0000, 8'h77); rd_n(2, r); chk("acmd41_a", r, 64'hFF01);
    chk("init_early", 64'(bus.initialized), 64'd0);
    cmd(8'h77, 32'h0, 8'h65); rd_n(2, r); chk("cmd55_b", r, 64'hFF01);
    cmd(8'h69, 32'h4000_0000, 8'h77); rd_n(2, r); chk("acmd41_b", r, 64'hFF00);
    chk("init_done", 64'(bus.initialized), 64'd1);
    cmd(8'h7A, 32'h0, 8'hFF); rd_n(6, r);
    chk("cmd58_r3", r, 64'hFF00_C0FF_8000);

    // full block read
    rq0 = rq_cnt;
    cmd(8'h51, 32'h10, 8'hFF); rd_n(5, r);
    chk("rd_head", r, 64'hFF_00_FF_FF_FE);
    dbad = 0;
    for (int k = 0; k < 512; k++) begin
      xfer(8'hFF, b);
      if (b != 8'(k)) dbad++;
    end
    chk("rd_data", 64'(dbad), 64'd0);
    rd_n(3, r);
    chk("rd_crc", r, 64'hFF_FFFF);
    chk("rd_reqs", 64'(rq_cnt - rq0), 64'd512);
    chk("rd_order", 64'(rq_bad), 64'd0);
    chk("rd_addr", 64'(bus.rd_addr), 64'h10);

    // full block write
    wv0 = wv_cnt;
    cmd(8'h58, 32'h20, 8'hFF); rd_n(2, r);
    chk("wr_r1", r, 64'hFF00);
    xfer(8'hFF, b);
    xfer(8'hFE, b);
    for (int k = 0; k < 512; k++) xfer(8'hA5, b);
    xfer(8'h12, b); xfer(8'h34, b);
    rd_n(6, r);
    chk("wr_tail", r, 64'h05_0000_0000_FF);
    chk("wr_count", 64'(wv_cnt - wv0), 64'd512);
    chk("wr_bytes", 64'(wv_bad), 64'd0);

    // deselect in the middle of data byte 100
    cmd(8'h51, 32'h0, 8'hFF); rd_n(5, r);
    chk("rd2_head", r, 64'hFF_00_FF_FF_FE);
    for (int k = 0; k < 100; k++) xfer(8'hFF, b);
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk); bus.spi_clk = 1'b1;
      repeat (3) @(negedge clk); bus.spi_clk = 1'b0;
    end
    cs_set(1'b1);
    chk("desel_miso", 64'(bus.miso), 64'd1);
    cs_set(1'b0);
    cmd(8'h4D, 32'h0, 8'hFF); rd_n(2, r);
    chk("cmd13_r1", r, 64'hFF04);

    // reset in the middle of a read
    cmd(8'h51, 32'h40, 8'hFF); rd_n(5, r);
    for (int k = 0; k < 20; k++) xfer(8'hFF, b);
    btn = 1'b1;
    @(negedge clk);
    chk("rst2_miso", 64'(bus.miso), 64'd1);
    chk("rst2_out", 64'({bus.initialized, bus.cmd_index, bus.rd_req, bus.rd_index, bus.wr_valid}), 64'd0);
    chk("rst2_addr", 64'(bus.rd_addr), 64'd0);
    btn = 1'b0;
    cs_set(1'b1);
    cs_set(1'b0);
    cmd(8'h51, 32'h0, 8'hFF); rd_n(3, r);
    chk("rst2_cmd17", r, 64'hFF05FF);
    cs_set(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
